// File: rtl/chart_pkg.sv
// Shared types for the chart recorder: FSM states and width helper.
package chart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECORD,
      FULL
   } chart_state_e;

   function automatic int unsigned cw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chart_ram.sv
// Chart storage: one synchronous write port, one asynchronous read port.
module chart_ram #(
   parameter int width_p = 8,
   parameter int depth_p = 6,
   localparam int AW = chart_pkg::cw(depth_p)
) (
   input  logic               clk_i,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic [width_p-1:0] wr_data_i,
   input  logic [AW-1:0]      rd_addr_i,
   output logic [width_p-1:0] rd_data_o
);

   logic [width_p-1:0] mem [depth_p];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
   end

   assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/chart_recorder.sv
// Records a valid/ready stream of chart entries into chart_ram.
// CHART_RECORDER_WRAP_EN: overwrite oldest entries instead of stopping at FULL.
module chart_recorder
   import chart_pkg::*;
#(
   parameter int width_p = 8,
   parameter int depth_p = 6,
   localparam int AW = cw(depth_p),
   localparam int CW = cw(depth_p + 1)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               wr_valid_i,
   input  logic [width_p-1:0] wr_data_i,
   output logic               wr_ready_o,
   input  logic [AW-1:0]      rd_addr_i,
   output logic [width_p-1:0] rd_data_o,
   output logic [CW-1:0]      count_o,
   output logic               full_o,
   output logic               recording_o
);

   localparam logic [AW-1:0] LAST_C  = AW'(depth_p - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(depth_p);
   localparam logic [CW-1:0] PRE_C   = CW'(depth_p - 1);

   chart_state_e      state;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              full_q;
   logic              accept;

   assign wr_ready_o  = (state == RECORD);
   assign recording_o = (state == RECORD);
   assign count_o     = count;
   assign full_o      = full_q;

   // A restart in the same cycle wins over any offered entry.
   assign accept = wr_valid_i && wr_ready_o && !start_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state  <= IDLE;
         wr_ptr <= '0;
         count  <= '0;
         full_q <= 1'b0;
      end else if (start_i) begin
         state  <= RECORD;
         wr_ptr <= '0;
         count  <= '0;
         full_q <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            if (count != DEPTH_C) count <= count + 1'b1;
            full_q <= (count == PRE_C) || (count == DEPTH_C);
         end
         unique case (state)
            RECORD: begin
               if (stop_i) state <= IDLE;
`ifndef CHART_RECORDER_WRAP_EN
               else if (accept && count == PRE_C) state <= FULL;
`endif
            end
            FULL: if (stop_i) state <= IDLE;
            default: ;
         endcase
      end
   end

   chart_ram #(
      .width_p (width_p),
      .depth_p (depth_p)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (accept),
      .wr_addr_i (wr_ptr),
      .wr_data_i (wr_data_i),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o)
   );

endmodule

// File: tb/tb_chart_recorder.sv
// Self-checking bench for chart_recorder against a behavioural chart model.
module tb_chart_recorder;

   localparam int D = 6;

   logic       clk = 1'b0;
   logic       reset_i = 1'b0;
   logic       start_i = 1'b0;
   logic       stop_i = 1'b0;
   logic       wr_valid_i = 1'b0;
   logic [7:0] wr_data_i = '0;
   logic       wr_ready_o;
   logic [2:0] rd_addr_i = '0;
   logic [7:0] rd_data_o;
   logic [2:0] count_o;
   logic       full_o;
   logic       recording_o;

   int vectors = 0;
   int miscompares = 0;

   // Model: a list of stored entries, a recording flag and a full flag.
   bit         m_rec = 0;
   bit         m_full = 0;
   int         m_cnt = 0;
   int         m_ptr = 0;
   logic [7:0] m_mem [D];
   bit         m_wr [D];

`ifdef CHART_RECORDER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   always #5 clk = ~clk;

   chart_recorder #(.width_p(8), .depth_p(D)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .wr_valid_i  (wr_valid_i),
      .wr_data_i   (wr_data_i),
      .wr_ready_o  (wr_ready_o),
      .rd_addr_i   (rd_addr_i),
      .rd_data_o   (rd_data_o),
      .count_o     (count_o),
      .full_o      (full_o),
      .recording_o (recording_o)
   );

   function automatic void model_step(bit rs, bit st, bit sp, bit v,
                                      logic [7:0] d);
      if (rs) begin
         m_rec = 0; m_full = 0; m_cnt = 0; m_ptr = 0;
      end else if (st) begin
         m_rec = 1; m_full = 0; m_cnt = 0; m_ptr = 0;
      end else if (m_rec) begin
         if (v) begin
            m_mem[m_ptr] = d;
            m_wr[m_ptr] = 1;
            m_ptr = (m_ptr + 1) % D;
            if (m_cnt < D) m_cnt++;
            if (!WRAP && m_cnt == D) begin
               m_rec = 0; m_full = 1;
            end
         end
         if (sp) begin
            m_rec = 0; m_full = 0;
         end
      end else if (m_full && sp) begin
         m_full = 0;
      end
   endfunction

   task automatic cyc(input bit rs, input bit st, input bit sp,
                      input bit v, input logic [7:0] d);
      reset_i = rs; start_i = st; stop_i = sp;
      wr_valid_i = v; wr_data_i = d;
      @(posedge clk);
      model_step(rs, st, sp, v, d);
      @(negedge clk);
      reset_i = 0; start_i = 0; stop_i = 0; wr_valid_i = 0;
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 8'h00);
      vectors++;
      if ({count_o, full_o, recording_o, wr_ready_o} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset: cnt/full/rec/rdy=%b required 000000",
                  {count_o, full_o, recording_o, wr_ready_o});
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp [3];
      exp = '{8'h11, 8'h22, 8'h33};
      cyc(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, exp[i]);
      vectors++;
      if (count_o !== 3'd3 || wr_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_count: count=%0d rdy=%b required 3 1",
                  count_o, wr_ready_o);
      end
      for (int i = 0; i < 3; i++) begin
         rd_addr_i = 3'(i);
         #1;
         vectors++;
         if (rd_data_o !== exp[i]) begin
            miscompares++;
            $display("FAIL basic_read[%0d]: got %h required %h",
                     i, rd_data_o, exp[i]);
         end
      end
   endtask

   task automatic test_fill();
      cyc(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < D; i++) cyc(0, 0, 0, 1, 8'hA0 + 8'(i));
      vectors++;
      if (full_o !== 1'b1 || wr_ready_o !== WRAP || count_o !== 3'd6) begin
         miscompares++;
         $display("FAIL fill: full=%b rdy=%b cnt=%0d required 1 %b 6",
                  full_o, wr_ready_o, count_o, WRAP);
      end
      cyc(0, 0, 0, 1, 8'hFF);
      rd_addr_i = 3'd0;
      #1;
      vectors++;
      if (rd_data_o !== (WRAP ? 8'hFF : 8'hA0) || count_o !== 3'd6) begin
         miscompares++;
         $display("FAIL overflow: addr0=%h cnt=%0d required %h 6",
                  rd_data_o, count_o, WRAP ? 8'hFF : 8'hA0);
      end
      rd_addr_i = 3'd5;
      #1;
      vectors++;
      if (rd_data_o !== 8'hA5) begin
         miscompares++;
         $display("FAIL last_entry: addr5=%h required a5", rd_data_o);
      end
      cyc(0, 0, 1, 0, 8'h00);
      vectors++;
      if (full_o !== 1'b1 || recording_o !== 1'b0) begin
         miscompares++;
         $display("FAIL stop_full: full=%b rec=%b required 1 0",
                  full_o, recording_o);
      end
   endtask

   task automatic test_stop_write();
      cyc(0, 1, 0, 0, 8'h00);
      cyc(0, 0, 1, 1, 8'h5A);
      rd_addr_i = 3'd0;
      #1;
      vectors++;
      if (rd_data_o !== 8'h5A || wr_ready_o !== 1'b0 ||
          recording_o !== 1'b0 || count_o !== 3'd1) begin
         miscompares++;
         $display("FAIL stop_write: d=%h rdy=%b rec=%b cnt=%0d required 5a 0 0 1",
                  rd_data_o, wr_ready_o, recording_o, count_o);
      end
   endtask

   task automatic test_start_stop();
      cyc(0, 1, 1, 0, 8'h00);
      vectors++;
      if (recording_o !== 1'b1 || count_o !== 3'd0) begin
         miscompares++;
         $display("FAIL start_stop: rec=%b cnt=%0d required 1 0",
                  recording_o, count_o);
      end
      cyc(0, 1, 0, 1, 8'h77);
      rd_addr_i = 3'd0;
      #1;
      vectors++;
      if (count_o !== 3'd0 || rd_data_o !== 8'h5A) begin
         miscompares++;
         $display("FAIL start_write: cnt=%0d addr0=%h required 0 5a",
                  count_o, rd_data_o);
      end
   endtask

   task automatic test_reset_mid();
      cyc(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 8'h40 + 8'(i));
      cyc(1, 0, 0, 0, 8'h00);
      rd_addr_i = 3'd3;
      #1;
      vectors++;
      if (count_o !== 3'd0 || recording_o !== 1'b0 ||
          wr_ready_o !== 1'b0 || rd_data_o !== 8'h43) begin
         miscompares++;
         $display("FAIL reset_mid: cnt=%0d rec=%b rdy=%b addr3=%h required 0 0 0 43",
                  count_o, recording_o, wr_ready_o, rd_data_o);
      end
   endtask

   task automatic test_bubbles();
      cyc(0, 1, 0, 0, 8'h00);
      cyc(0, 0, 0, 1, 8'hB0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 8'hEE);
         vectors++;
         if (count_o !== 3'd1) begin
            miscompares++;
            $display("FAIL bubble_hold[%0d]: cnt=%0d required 1", i, count_o);
         end
      end
      cyc(0, 0, 0, 1, 8'hB1);
      rd_addr_i = 3'd1;
      #1;
      vectors++;
      if (count_o !== 3'd2 || rd_data_o !== 8'hB1) begin
         miscompares++;
         $display("FAIL bubble_contig: cnt=%0d addr1=%h required 2 b1",
                  count_o, rd_data_o);
      end
   endtask

   task automatic test_random();
      int a;
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
             $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 60,
             8'($urandom));
         vectors++;
         if (count_o !== 3'(m_cnt) || full_o !== (m_cnt == D) ||
             recording_o !== m_rec || wr_ready_o !== m_rec) begin
            miscompares++;
            $display("FAIL rand_state[%0d]: cnt=%0d full=%b rec=%b rdy=%b required %0d %b %b %b",
                     n, count_o, full_o, recording_o, wr_ready_o,
                     m_cnt, m_cnt == D, m_rec, m_rec);
         end
         a = $urandom_range(0, D - 1);
         if (m_wr[a]) begin
            rd_addr_i = 3'(a);
            #1;
            vectors++;
            if (rd_data_o !== m_mem[a]) begin
               miscompares++;
               $display("FAIL rand_read[%0d]: addr%0d=%h required %h",
                        n, a, rd_data_o, m_mem[a]);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_fill();
      test_stop_write();
      test_start_stop();
      test_reset_mid();
      test_bubbles();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
